// File: rtl/vga_out_stage_if.sv
// rtl/vga_out_stage_if.sv - timing/colour inputs and pin-side outputs of the VGA output stage
// Master drives the timing and renderer signals; slave is the output stage.

interface vga_out_stage_if #(
   parameter int FRAME_W = 16
);
   logic               hsync_in;
   logic               vsync_in;
   logic               display_on_in;
   logic [5:0]         rgb_in;
   logic               freeze;
   logic               step;
   logic [7:0]         uo_out;
   logic               activevideo;
   logic [FRAME_W-1:0] frame_cnt;
   logic               frame_tick;
   logic               line_tick;

   modport master (
      output hsync_in, vsync_in, display_on_in, rgb_in, freeze, step,
      input  uo_out, activevideo, frame_cnt, frame_tick, line_tick
   );

   modport slave (
      input  hsync_in, vsync_in, display_on_in, rgb_in, freeze, step,
      output uo_out, activevideo, frame_cnt, frame_tick, line_tick
   );
endinterface

// File: rtl/vga_out_stage.sv
// rtl/vga_out_stage.sv - sync delay line, colour blanking, packed uo_out pins and frame counter
// Timing reaches the pins PIPE_DEPTH cycles after input; colour is registered once into uo_out.

module vga_out_stage #(
   parameter int PIPE_DEPTH = 2,
   parameter int FRAME_W    = 16,
   parameter int OUT_INVERT = 0
) (
   input logic            clk,
   input logic            rst_n,
   vga_out_stage_if.slave bus
);
   localparam logic       INV      = (OUT_INVERT != 0);
   localparam logic [7:0] UO_RESET = {INV, 3'b000, INV, 3'b000};

   // Timing values one stage before the pin register (PIPE_DEPTH-1 cycles late).
   logic hs_pre;
   logic vs_pre;
   logic de_pre;

   generate
      if (PIPE_DEPTH > 1) begin : g_pipe
         logic [PIPE_DEPTH-2:0] hs_q, hs_d;
         logic [PIPE_DEPTH-2:0] vs_q, vs_d;
         logic [PIPE_DEPTH-2:0] de_q, de_d;

         always_comb begin
            hs_d    = hs_q << 1;
            vs_d    = vs_q << 1;
            de_d    = de_q << 1;
            hs_d[0] = bus.hsync_in;
            vs_d[0] = bus.vsync_in;
            de_d[0] = bus.display_on_in;
         end

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               hs_q <= '0;
               vs_q <= '0;
               de_q <= '0;
            end else begin
               hs_q <= hs_d;
               vs_q <= vs_d;
               de_q <= de_d;
            end
         end

         assign hs_pre = hs_q[PIPE_DEPTH-2];
         assign vs_pre = vs_q[PIPE_DEPTH-2];
         assign de_pre = de_q[PIPE_DEPTH-2];
      end else begin : g_direct
         assign hs_pre = bus.hsync_in;
         assign vs_pre = bus.vsync_in;
         assign de_pre = bus.display_on_in;
      end
   endgenerate

   logic [7:0]         uo_out_q, uo_out_d;
   logic               hs_pin_q, hs_pin_d;
   logic               vs_pin_q, vs_pin_d;
   logic               activevideo_q, activevideo_d;
   logic               line_tick_q, line_tick_d;
   logic               frame_tick_q, frame_tick_d;
   logic               step_lat_q, step_lat_d;
   logic [FRAME_W-1:0] frame_cnt_q, frame_cnt_d;
   logic [5:0]         rgb_gated;
   logic               step_now;

   always_comb begin
      rgb_gated     = de_pre ? bus.rgb_in : 6'd0;
      uo_out_d      = {hs_pre ^ INV, rgb_gated[0], rgb_gated[2], rgb_gated[4],
                       vs_pre ^ INV, rgb_gated[1], rgb_gated[3], rgb_gated[5]};
      hs_pin_d      = hs_pre;
      vs_pin_d      = vs_pre;
      activevideo_d = de_pre;
      // Ticks are edges of the un-inverted syncs as they land on the pins.
      line_tick_d   = hs_pre & ~hs_pin_q;
      frame_tick_d  = vs_pre & ~vs_pin_q;

      step_now    = step_lat_q | (bus.freeze & bus.step);
      frame_cnt_d = frame_cnt_q;
      step_lat_d  = step_lat_q;
      if (!bus.freeze) begin
         step_lat_d = 1'b0;
      end else if (bus.step) begin
         step_lat_d = 1'b1;
      end
      if (frame_tick_q) begin
         if (!bus.freeze || step_now) begin
            frame_cnt_d = frame_cnt_q + 1'b1;
         end
         if (bus.freeze && step_now) begin
            step_lat_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         uo_out_q      <= UO_RESET;
         hs_pin_q      <= 1'b0;
         vs_pin_q      <= 1'b0;
         activevideo_q <= 1'b0;
         line_tick_q   <= 1'b0;
         frame_tick_q  <= 1'b0;
         step_lat_q    <= 1'b0;
         frame_cnt_q   <= '0;
      end else begin
         uo_out_q      <= uo_out_d;
         hs_pin_q      <= hs_pin_d;
         vs_pin_q      <= vs_pin_d;
         activevideo_q <= activevideo_d;
         line_tick_q   <= line_tick_d;
         frame_tick_q  <= frame_tick_d;
         step_lat_q    <= step_lat_d;
         frame_cnt_q   <= frame_cnt_d;
      end
   end

   assign bus.uo_out      = uo_out_q;
   assign bus.activevideo = activevideo_q;
   assign bus.line_tick   = line_tick_q;
   assign bus.frame_tick  = frame_tick_q;
   assign bus.frame_cnt   = frame_cnt_q;
endmodule

// File: tb/tb_vga_out_stage.sv
// tb/tb_vga_out_stage.sv - vector table, directed sequences and random run against a history-based model
// Expected pins are derived from the recorded input history of each cycle.

module tb_vga_out_stage;
   localparam int PD = 2;
   localparam int FW = 4;
   localparam int HN = 8192;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   vga_out_stage_if #(.FRAME_W(FW)) bus ();

   vga_out_stage #(.PIPE_DEPTH(PD), .FRAME_W(FW), .OUT_INVERT(0)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   typedef struct packed {
      logic       h;
      logic       v;
      logic       de;
      logic [5:0] rgb;
      logic       frz;
      logic       stp;
   } in_t;

   typedef struct packed {
      logic       h;
      logic       v;
      logic       de;
      logic [5:0] rgb;
      logic [7:0] uo;
      logic       av;
      logic       ft;
      logic       lt;
      logic [3:0] cnt;
   } vec_t;

   in_t  hist [0:HN-1];
   int   cyc = -1;
   int   base = 0;
   bit   in_reset = 1'b1;
   bit   release_pending = 1'b0;
   logic [3:0] mcnt = '0;
   bit   owed = 1'b0;

   int errors = 0;
   int checks = 0;

   logic [7:0] obs_uo;
   logic       obs_av, obs_ft, obs_lt;
   logic [3:0] obs_cnt;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s (cycle %0d): got 0x%0h expected 0x%0h", name, cyc, act, exp);
      end
   endtask

   function automatic in_t at(input int i);
      if (i < base || i < 0) return '0;
      return hist[i];
   endfunction

   task automatic cycle(input logic h, input logic v, input logic de, input logic [5:0] rgb,
                        input logic frz, input logic stp);
      in_t a, p, r, cur;
      logic [5:0] col;
      logic [14:0] expv, obsv;
      @(posedge clk);
      #1;
      cyc++;
      if (cyc >= HN) begin
         $display("FAIL history_overflow: got cycle %0d expected below %0d", cyc, HN);
         $fatal(1, "history overflow");
      end
      if (release_pending) begin
         rst_n = 1'b1;
         in_reset = 1'b0;
         release_pending = 1'b0;
         base = cyc;
         mcnt = '0;
         owed = 1'b0;
      end
      bus.hsync_in      = h;
      bus.vsync_in      = v;
      bus.display_on_in = de;
      bus.rgb_in        = rgb;
      bus.freeze        = frz;
      bus.step          = stp;
      cur = '{h: h, v: v, de: de, rgb: rgb, frz: frz, stp: stp};
      hist[cyc] = cur;
      @(negedge clk);
      obs_uo  = bus.uo_out;
      obs_av  = bus.activevideo;
      obs_ft  = bus.frame_tick;
      obs_lt  = bus.line_tick;
      obs_cnt = bus.frame_cnt;
      obsv = {obs_uo, obs_av, obs_ft, obs_lt, obs_cnt};
      if (in_reset) begin
         check("reset_outputs", {17'd0, obsv}, 32'd0);
      end else begin
         // Pins show timing from PD cycles ago and colour from the previous cycle.
         a = at(cyc - PD);
         p = at(cyc - PD - 1);
         r = at(cyc - 1);
         col = a.de ? r.rgb : 6'd0;
         expv = {a.h, col[0], col[2], col[4], a.v, col[1], col[3], col[5],
                 a.de, a.v & ~p.v, a.h & ~p.h, mcnt};
         check("model", {17'd0, obsv}, {17'd0, expv});
         if (a.v && !p.v && (!cur.frz || owed || cur.stp)) mcnt = mcnt + 4'd1;
         owed = cur.frz && (owed || cur.stp) && !(a.v && !p.v);
      end
   endtask

   task automatic async_reset();
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      in_reset = 1'b1;
      #1;
      check("async_reset_uo", {24'd0, bus.uo_out}, 32'd0);
      check("async_reset_cnt", {28'd0, bus.frame_cnt}, 32'd0);
      for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 1'b1, 6'h3F, 1'b0, 1'b0);
      release_pending = 1'b1;
   endtask

   task automatic frame(input logic frz, input logic [9:0] stp_mask,
                        output int first_vs, output int first_ft);
      first_vs = -1;
      first_ft = -1;
      for (int i = 0; i < 10; i++) begin
         cycle(1'b0, (i < 3), 1'b0, 6'h00, frz, stp_mask[i]);
         if (obs_uo[3] && first_vs < 0) first_vs = i;
         if (obs_ft && first_ft < 0) first_ft = i;
      end
   endtask

   vec_t tbl [0:7];

   initial begin
      #1000000;
      $display("FAIL watchdog: got time limit expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      int fv, ff, first, last, cnt1, cnt2, tick_total;
      logic h, v, de, frz;

      tbl[0] = '{1'b1, 1'b0, 1'b0, 6'h3F, 8'h00, 1'b0, 1'b0, 1'b0, 4'd0};
      tbl[1] = '{1'b1, 1'b1, 1'b1, 6'h3F, 8'h00, 1'b0, 1'b0, 1'b0, 4'd0};
      tbl[2] = '{1'b0, 1'b1, 1'b1, 6'h15, 8'h80, 1'b0, 1'b0, 1'b1, 4'd0};
      tbl[3] = '{1'b0, 1'b0, 1'b0, 6'h2A, 8'hF8, 1'b1, 1'b1, 1'b0, 4'd0};
      tbl[4] = '{1'b0, 1'b0, 1'b0, 6'h3F, 8'h0F, 1'b1, 1'b0, 1'b0, 4'd1};
      tbl[5] = '{1'b0, 1'b0, 1'b0, 6'h00, 8'h00, 1'b0, 1'b0, 1'b0, 4'd1};
      tbl[6] = '{1'b0, 1'b0, 1'b0, 6'h00, 8'h00, 1'b0, 1'b0, 1'b0, 4'd1};
      tbl[7] = '{1'b0, 1'b0, 1'b0, 6'h00, 8'h00, 1'b0, 1'b0, 1'b0, 4'd1};

      bus.hsync_in = 1'b0; bus.vsync_in = 1'b0; bus.display_on_in = 1'b0;
      bus.rgb_in = 6'h00; bus.freeze = 1'b0; bus.step = 1'b0;

      // Reset held with arbitrary inputs.
      for (int i = 0; i < 4; i++)
         cycle(1'($urandom), 1'($urandom), 1'($urandom), 6'($urandom), 1'($urandom), 1'($urandom));
      release_pending = 1'b1;

      for (int i = 0; i < 8; i++) begin
         cycle(tbl[i].h, tbl[i].v, tbl[i].de, tbl[i].rgb, 1'b0, 1'b0);
         check($sformatf("table_row%0d", i), {17'd0, obs_uo, obs_av, obs_ft, obs_lt, obs_cnt},
               {17'd0, tbl[i].uo, tbl[i].av, tbl[i].ft, tbl[i].lt, tbl[i].cnt});
      end

      // Latency: hsync high on relative cycles 10..105.
      first = -1; last = -1; cnt1 = 0; cnt2 = -1;
      for (int i = 0; i < 116; i++) begin
         cycle((i >= 10 && i <= 105), 1'b0, 1'b0, 6'h00, 1'b0, 1'b0);
         if (obs_uo[7]) begin
            if (first < 0) first = i;
            last = i;
         end
         if (obs_lt) begin
            cnt1++;
            cnt2 = i;
         end
      end
      check("hsync_first", first, 12);
      check("hsync_last", last, 107);
      check("line_tick_count", cnt1, 1);
      check("line_tick_cycle", cnt2, 12);

      // Blanking: display_on high on relative cycles 10..19, rgb all ones.
      first = -1; last = -1; cnt1 = 0; cnt2 = 0;
      for (int i = 0; i < 30; i++) begin
         cycle(1'b0, 1'b0, (i >= 10 && i <= 19), 6'h3F, 1'b0, 1'b0);
         if ((obs_uo & 8'h77) == 8'h77) begin
            if (first < 0) first = i;
            last = i;
            cnt1++;
         end
         if (obs_av) cnt2++;
         if (obs_av != ((obs_uo & 8'h77) == 8'h77)) check("activevideo_align", {31'd0, obs_av}, {31'd0, ~obs_av});
      end
      check("colour_first", first, 12);
      check("colour_last", last, 21);
      check("colour_count", cnt1, 10);
      check("activevideo_count", cnt2, 10);

      // Simultaneous hsync and vsync rising edges.
      cnt1 = 0;
      for (int i = 0; i < 10; i++) begin
         cycle((i >= 3 && i < 6), (i >= 3 && i < 6), 1'b0, 6'h00, 1'b0, 1'b0);
         if (obs_ft && obs_lt) cnt1++;
      end
      check("both_ticks_same_cycle", cnt1, 1);

      // Frame counter wrap from a fresh reset.
      async_reset();
      for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b0, 6'h00, 1'b0, 1'b0);
      tick_total = 0;
      for (int k = 1; k <= 17; k++) begin
         frame(1'b0, 10'd0, fv, ff);
         if (ff >= 0) tick_total++;
         check($sformatf("frame_cnt_after_%0d", k), {28'd0, obs_cnt}, k % 16);
      end
      check("frame_tick_total", tick_total, 17);

      // Freeze and step.
      for (int k = 0; k < 3; k++) begin
         frame(1'b1, 10'd0, fv, ff);
         check("frozen_hold", {28'd0, obs_cnt}, 32'd1);
         check("frozen_tick_still_pulses", ff, 2);
      end
      frame(1'b1, 10'b1010100000, fv, ff);
      check("steps_before_vsync", {28'd0, obs_cnt}, 32'd1);
      frame(1'b1, 10'd0, fv, ff);
      check("three_steps_one_inc", {28'd0, obs_cnt}, 32'd2);
      frame(1'b1, 10'd0, fv, ff);
      check("step_latch_consumed", {28'd0, obs_cnt}, 32'd2);
      frame(1'b1, 10'b0000000100, fv, ff);
      check("step_on_tick_cycle", {28'd0, obs_cnt}, 32'd3);
      frame(1'b0, 10'd0, fv, ff);
      check("unfreeze_resume_1", {28'd0, obs_cnt}, 32'd4);
      frame(1'b0, 10'd0, fv, ff);
      check("unfreeze_resume_2", {28'd0, obs_cnt}, 32'd5);

      // Reset during active video.
      for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, 1'b1, 6'h3F, 1'b0, 1'b0);
      async_reset();
      for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b0, 6'h00, 1'b0, 1'b0);
      check("cnt_after_reset", {28'd0, obs_cnt}, 32'd0);
      frame(1'b0, 10'd0, fv, ff);
      check("vsync_latency_after_reset", fv, PD);
      check("frame_tick_after_reset", ff, PD);
      check("cnt_restart", {28'd0, obs_cnt}, 32'd1);

      // Random run against the model.
      h = 0; v = 0; de = 0; frz = 0;
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(7) == 0) h = ~h;
         if ($urandom_range(19) == 0) v = ~v;
         if ($urandom_range(3) == 0) de = ~de;
         if ($urandom_range(49) == 0) frz = ~frz;
         cycle(h, v, de, 6'($urandom), frz, ($urandom_range(9) == 0));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
